// File: rtl/matrix_alu_sequencer_pkg.sv
// Shared definitions for the matrix ALU sequencer: opcodes, lane geometry,
// sequencer state encoding and lane pack/unpack helpers.
package matrix_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;

  localparam int LANE_W = 32;
  localparam int ROWS   = 4;
  localparam int LANES  = 4;
  localparam int ROW_W  = LANE_W * LANES;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP_B,
    EXEC,
    WR,
    FIN
  } seq_state_t;

  function automatic logic signed [LANE_W-1:0] lane_get(input logic [ROW_W-1:0] row,
                                                        input int idx);
    return row[idx*LANE_W +: LANE_W];
  endfunction

  function automatic logic [ROW_W-1:0] lane_set(input logic [ROW_W-1:0] row,
                                                input int idx,
                                                input logic signed [LANE_W-1:0] val);
    logic [ROW_W-1:0] r;
    r = row;
    r[idx*LANE_W +: LANE_W] = val;
    return r;
  endfunction

endpackage

// File: rtl/matrix_alu_sequencer_if.sv
// Command, memory and ALU bus of the matrix ALU sequencer; master is the
// sequencer, slave is the CPU/memory/ALU environment around it.
interface matrix_alu_sequencer_if #(
  parameter int AW = 8
);
  import matrix_pkg::*;

  logic             CmdValid;
  logic             CmdReady;
  logic [2:0]       CmdOp;
  logic [AW-1:0]    CmdSrcA;
  logic [AW-1:0]    CmdSrcB;
  logic [AW-1:0]    CmdDest;

  logic             MemRead;
  logic             MemWrite;
  logic [AW-1:0]    MemAddr;
  logic [ROW_W-1:0] MemWriteData;
  logic [ROW_W-1:0] MemReadData;

  logic [2:0]       AluOperation;
  logic [ROW_W-1:0] AluColumnA;
  logic [ROW_W-1:0] AluColumnB;
  logic [ROW_W-1:0] AluResult;
  logic             AluDone;
  logic             AluError;

  logic             Done;
  logic             Error;

  modport master (
    input  CmdValid, CmdOp, CmdSrcA, CmdSrcB, CmdDest,
    output CmdReady,
    output MemRead, MemWrite, MemAddr, MemWriteData,
    input  MemReadData,
    output AluOperation, AluColumnA, AluColumnB,
    input  AluResult, AluDone, AluError,
    output Done, Error
  );

  modport slave (
    output CmdValid, CmdOp, CmdSrcA, CmdSrcB, CmdDest,
    input  CmdReady,
    input  MemRead, MemWrite, MemAddr, MemWriteData,
    output MemReadData,
    input  AluOperation, AluColumnA, AluColumnB,
    output AluResult, AluDone, AluError,
    input  Done, Error
  );

endinterface

// File: rtl/matrix_alu_sequencer.sv
// Runs one 4x4 matrix operation row by row through the shared matrix ALU:
// fetch A row, fetch B row, execute, write back, with an ALU watchdog.
module matrix_alu_sequencer #(
  parameter int AW      = 8,
  parameter int ROWS    = 4,
  parameter int TIMEOUT = 15
) (
  input logic                    Clock,
  input logic                    ClearAll,
  matrix_alu_sequencer_if.master bus
);
  import matrix_pkg::*;

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  seq_state_t       state, state_nxt;
  logic [2:0]       op;
  logic [AW-1:0]    src_a, src_b, dest;
  logic [RW-1:0]    row;
  logic [WDW-1:0]   wdog;
  logic [ROW_W-1:0] row_a, row_b, result;
  logic             err;

  logic          accept, alu_ok, alu_fail, last_row;
  logic [AW-1:0] row_addr;

  assign accept   = (state == IDLE) && bus.CmdValid;
  assign alu_ok   = (state == EXEC) && bus.AluDone && !bus.AluError;
  // A Done arriving on the expiry cycle still counts as Done.
  assign alu_fail = (state == EXEC) &&
                    ((bus.AluDone && bus.AluError) ||
                     (!bus.AluDone && (wdog == WDW'(TIMEOUT - 1))));
  assign last_row = (row == RW'(ROWS - 1));
  assign row_addr = AW'(row);

  always_ff @(posedge Clock) begin
    if (ClearAll) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.CmdValid) state_nxt = (bus.CmdOp == OP_NOP) ? FIN : RD_A;
      RD_A:    state_nxt = RD_B;
      RD_B:    state_nxt = CAP_B;
      CAP_B:   state_nxt = EXEC;
      EXEC: begin
        if (alu_ok)        state_nxt = WR;
        else if (alu_fail) state_nxt = FIN;
      end
      WR:      state_nxt = last_row ? FIN : RD_A;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (ClearAll) begin
      row  <= '0;
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      if (accept) begin
        row <= '0;
        err <= 1'b0;
      end else if ((state == WR) && !last_row) begin
        row <= row + 1'b1;
      end
      if (state == CAP_B)     wdog <= '0;
      else if (state == EXEC) wdog <= wdog + 1'b1;
      if (alu_fail) err <= 1'b1;
    end
  end

  // Data capture carries no reset; outputs are gated by state instead.
  always_ff @(posedge Clock) begin
    if (accept) begin
      op    <= bus.CmdOp;
      src_a <= bus.CmdSrcA;
      src_b <= bus.CmdSrcB;
      dest  <= bus.CmdDest;
    end
    if (state == RD_B)  row_a  <= bus.MemReadData;
    if (state == CAP_B) row_b  <= bus.MemReadData;
    if (alu_ok)         result <= bus.AluResult;
  end

  always_comb begin
    bus.CmdReady     = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.MemAddr      = '0;
    bus.MemWriteData = '0;
    bus.AluOperation = OP_NOP;
    bus.AluColumnA   = '0;
    bus.AluColumnB   = '0;
    bus.Done         = 1'b0;
    case (state)
      IDLE: bus.CmdReady = 1'b1;
      RD_A: begin
        bus.MemRead = 1'b1;
        bus.MemAddr = src_a + row_addr;
      end
      RD_B: begin
        bus.MemRead = 1'b1;
        bus.MemAddr = src_b + row_addr;
      end
      EXEC: begin
        bus.AluOperation = op;
        bus.AluColumnA   = row_a;
        bus.AluColumnB   = row_b;
      end
      WR: begin
        bus.MemWrite     = 1'b1;
        bus.MemAddr      = dest + row_addr;
        bus.MemWriteData = result;
      end
      FIN:     bus.Done = 1'b1;
      default: ;
    endcase
  end

  assign bus.Error = err;

endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// Directed bench for matrix_alu_sequencer with a memory model, a lane-adder
// ALU model and a per-cycle comparison against an expected-event model.
`timescale 1ns/1ps
module tb_matrix_alu_sequencer;
  import matrix_pkg::*;

  localparam int AW      = 8;
  localparam int TIMEOUT = 15;

  logic Clock = 1'b0;
  logic ClearAll = 1'b1;
  always #5 Clock = ~Clock;

  matrix_alu_sequencer_if #(.AW(AW)) bus();

  matrix_alu_sequencer #(.AW(AW), .ROWS(4), .TIMEOUT(TIMEOUT)) dut (
    .Clock    (Clock),
    .ClearAll (ClearAll),
    .bus      (bus)
  );

  int edges = 0;
  always @(posedge Clock) edges <= edges + 1;

  // Source memory is preloaded by the stimulus; results land in wmem.
  logic [127:0] mem  [256];
  logic [127:0] wmem [256];
  logic [127:0] rd_q;
  always @(posedge Clock) begin
    if (bus.MemRead)  rd_q <= mem[bus.MemAddr];
    if (bus.MemWrite) wmem[bus.MemAddr] <= bus.MemWriteData;
  end
  assign bus.MemReadData = rd_q;

  function automatic logic [127:0] add_rows(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] s;
    for (int i = 0; i < 4; i++) s[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    return s;
  endfunction

  // ALU model: mode 0 = Done after alu_lat cycles, 1 = never Done,
  // 2 = Done with Error on window alu_err_row.
  int alu_lat = 2, alu_mode = 0, alu_err_row = 0;
  int alu_cnt = 0, alu_win = 0;
  always @(negedge Clock) begin
    if (bus.AluOperation != 3'b000) begin
      if (alu_cnt == 0) alu_win = alu_win + 1;
      alu_cnt = alu_cnt + 1;
      bus.AluDone   = (alu_mode != 1) && (alu_cnt == alu_lat);
      bus.AluError  = bus.AluDone && (alu_mode == 2) && ((alu_win - 1) == alu_err_row);
      bus.AluResult = add_rows(bus.AluColumnA, bus.AluColumnB);
    end else begin
      alu_cnt      = 0;
      bus.AluDone  = 1'b0;
      bus.AluError = 1'b0;
      if (bus.CmdReady) alu_win = 0;
    end
  end

  int vectors = 0, miscompares = 0;
  logic [AW-1:0]  exp_rd[$];
  logic [AW-1:0]  exp_wa[$];
  logic [127:0]   exp_wd[$];
  int  acc_edge = 0, exp_done_idx = 0, done_cnt = 0, done_seen = 0;
  bit  cmd_active = 0, checking = 0;
  logic [2:0] cur_op = 3'b000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h expected no such event", name, act);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge Clock);
      if (checking) begin
        int idx;
        idx = edges - acc_edge + 1;
        checki("cmd_ready", int'(bus.CmdReady),
               int'(!(cmd_active && idx >= 1 && idx <= exp_done_idx)));
        if (bus.AluOperation != 3'b000) checki("alu_op", int'(bus.AluOperation), int'(cur_op));
        if (bus.MemRead) begin
          if (exp_rd.size() == 0) flag("extra_read", int'(bus.MemAddr));
          else check("read_addr", 128'(bus.MemAddr), 128'(exp_rd.pop_front()));
        end
        if (bus.MemWrite) begin
          if (exp_wa.size() == 0) flag("extra_write", int'(bus.MemAddr));
          else begin
            check("write_addr", 128'(bus.MemAddr), 128'(exp_wa.pop_front()));
            check("write_data", bus.MemWriteData, exp_wd.pop_front());
          end
        end
        if (bus.Done) begin
          if (!cmd_active) flag("spurious_done", idx);
          else begin
            checki("done_cycle", idx, exp_done_idx);
            done_seen = idx;
            done_cnt++;
          end
        end
      end
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                         input logic [AW-1:0] d, input int lat, input int mode,
                         input int err_row, input int clear_at);
    bit finished;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    if (op != OP_NOP) begin
      for (int r = 0; r < 4; r++) begin
        exp_rd.push_back(sa + AW'(r));
        exp_rd.push_back(sb + AW'(r));
        if (mode == 1 || (mode == 2 && r == err_row) || (clear_at > 0 && r == 1)) break;
        exp_wa.push_back(d + AW'(r));
        exp_wd.push_back(add_rows(mem[sa + AW'(r)], mem[sb + AW'(r)]));
      end
    end
    if (op == OP_NOP)   exp_done_idx = 1;
    else if (mode == 1) exp_done_idx = 3 + TIMEOUT + 1;
    else if (mode == 2) exp_done_idx = err_row * (4 + lat) + 3 + lat + 1;
    else                exp_done_idx = 4 * (4 + lat) + 1;
    if (clear_at > 0)   exp_done_idx = 1000;
    alu_lat = lat; alu_mode = mode; alu_err_row = err_row;
    @(negedge Clock);
    cur_op = op;
    done_cnt = 0; done_seen = 0;
    acc_edge = edges + 1;
    cmd_active = 1;
    bus.CmdOp = op; bus.CmdSrcA = sa; bus.CmdSrcB = sb; bus.CmdDest = d;
    bus.CmdValid = 1'b1;
    @(posedge Clock);
    #1 bus.CmdValid = 1'b0;
    finished = 0;
    for (int n = 0; n < 400 && !finished; n++) begin
      int idx;
      @(negedge Clock);
      idx = edges - acc_edge + 1;
      if (idx == 1) checki("error_cleared_on_accept", int'(bus.Error), 0);
      if (clear_at > 0 && idx == clear_at) begin
        ClearAll = 1'b1;
        @(posedge Clock);
        #1 cmd_active = 0;
        ClearAll = 1'b0;
        @(negedge Clock);
        checki("clr_ready", int'(bus.CmdReady), 1);
        checki("clr_done", int'(bus.Done), 0);
        checki("clr_memread", int'(bus.MemRead), 0);
        checki("clr_aluop", int'(bus.AluOperation), 0);
        checki("clr_error", int'(bus.Error), 0);
        checki("clr_done_count", done_cnt, 0);
        finished = 1;
      end else if (done_cnt > 0) begin
        finished = 1;
      end
    end
    if (!finished) flag("cmd_no_done", edges - acc_edge + 1);
    @(negedge Clock);
    if (clear_at == 0) begin
      checki("ready_after", int'(bus.CmdReady), 1);
      checki("error_flag", int'(bus.Error), int'(mode != 0));
      checki("done_count", done_cnt, 1);
    end
    checki("reads_left", exp_rd.size(), 0);
    checki("writes_left", exp_wa.size(), 0);
    cmd_active = 0;
  endtask

  logic [127:0] six, wrap_row;

  initial begin
    six      = {4{32'd6}};
    wrap_row = {32'h80000000, 32'h00000000, 32'hFFFFFF38, 32'h7FFFFFFF};
    bus.CmdValid = 1'b0; bus.CmdOp = 3'b000;
    bus.CmdSrcA = '0; bus.CmdSrcB = '0; bus.CmdDest = '0;
    for (int r = 0; r < 4; r++) begin
      mem[r]        = {4{32'hFFFFFFFC}};
      mem[8'h10 + r] = {4{32'd10}};
      for (int i = 0; i < 4; i++) begin
        mem[8'h40 + r][32*i +: 32] = 32'(r * 16 + i + 100);
        mem[8'h50 + r][32*i +: 32] = 32'(-(i * 3 + r));
      end
    end
    mem[8'h42] = {32'h7FFFFFFF, 32'hFFFFFFFF, 32'd100, 32'h80000000};
    mem[8'h52] = {32'd1, 32'd1, 32'hFFFFFED4, 32'hFFFFFFFF};
    fork compare_loop(); join_none

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checki("rst_ready", int'(bus.CmdReady), 1);
    checki("rst_done", int'(bus.Done), 0);
    checki("rst_error", int'(bus.Error), 0);
    checki("rst_memread", int'(bus.MemRead), 0);
    checki("rst_memwrite", int'(bus.MemWrite), 0);
    checki("rst_memaddr", int'(bus.MemAddr), 0);
    checki("rst_aluop", int'(bus.AluOperation), 0);
    check("rst_cola", bus.AluColumnA, 128'd0);
    ClearAll = 1'b0;
    checking = 1;

    run_cmd(OP_ADD, 8'h00, 8'h10, 8'h20, 2, 0, 0, 0);
    checki("t1_done_at", done_seen, 25);
    for (int r = 0; r < 4; r++) check("t1_row", wmem[8'h20 + r], six);

    run_cmd(OP_NOP, 8'h00, 8'h10, 8'h90, 2, 0, 0, 0);
    checki("nop_done_at", done_seen, 1);

    run_cmd(OP_ADD, 8'h40, 8'h50, 8'hA0, 2, 1, 0, 0);
    checki("timeout_done_at", done_seen, 19);
    repeat (3) @(negedge Clock);
    checki("error_held", int'(bus.Error), 1);

    run_cmd(OP_ADD, 8'h40, 8'h50, 8'hB0, 3, 2, 2, 0);
    checki("alu_err_done_at", done_seen, 21);

    run_cmd(3'b101, 8'h40, 8'h50, 8'hFE, 1, 0, 0, 0);
    check("wrap_row2", wmem[8'h00], wrap_row);

    run_cmd(OP_ADD, 8'h40, 8'h50, 8'hC0, 2, 0, 0, 10);
    run_cmd(OP_ADD, 8'h00, 8'h10, 8'hD0, 2, 0, 0, 0);
    for (int r = 0; r < 4; r++) check("after_clear_row", wmem[8'hD0 + r], six);

    repeat (2) @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_alu_sequencer.md
# matrix_alu_sequencer

Command-driven controller that runs one whole 4x4 signed-32-bit matrix operation through the shared 4-lane matrix ALU (Adder). Each matrix row is a 128-bit memory word. For every row, the block fetches row r of matrices A and B from data memory, presents them to the ALU with the command's operation code, waits for the ALU's Done, and writes the result row back to memory. It sits between the CPU command port and the ALU/memory pair, so software issues a single command instead of driving the ALU row by row.

## Interface
Parameters:
- AW, 8: memory word-address width.
- ROWS, 4: rows per matrix.
- TIMEOUT, 15: maximum cycles to wait for AluDone per row.

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- ClearAll  in  1  synchronous, active-high reset.
- CmdValid  in  1  command request.
- CmdReady  out  1  high only in IDLE; a command is accepted when CmdValid and CmdReady are both high at the edge.
- CmdOp  in  3  ALU operation code, passed to the ALU unchanged.
- CmdSrcA, CmdSrcB, CmdDest  in  AW  base word addresses of matrix A, matrix B and the result.
- MemRead  out  1  read strobe. Read data is valid on MemReadData in the following cycle.
- MemWrite  out  1  write strobe.
- MemAddr  out  AW  memory word address.
- MemWriteData  out  128  result row. Lane i = bits [32i+31:32i], i = 0..3.
- MemReadData  in  128  row read from memory; same lane mapping.
- AluOperation  out  3  drives the ALU Operation input.
- AluColumnA, AluColumnB  out  128  lane i drives ALU ColumnA(i+1) / ColumnB(i+1).
- AluResult  in  128  ALU NewColumn1..4 packed in lanes 0..3.
- AluDone, AluError  in  1  ALU status.
- Done  out  1  one-cycle pulse when a command finishes, whether it completed or aborted.
- Error  out  1  set on abort; held until the next command is accepted.

## Operation
- States: IDLE, RD_A, RD_B, CAP_B, EXEC, WR, FIN.
- All outputs are registered or decoded from the state register (Moore). Reset value of every output is 0, except CmdReady = 1.
- IDLE, on accept:
  - Latch CmdOp and the three base addresses.
  - Set row counter r = 0 and clear Error.
  - If CmdOp == 3'b000 (NOP), go directly to FIN with no memory or ALU traffic. Otherwise go to RD_A.
- RD_A: MemRead = 1, MemAddr = SrcA + r.
- RD_B: capture MemReadData into the A row register. MemRead = 1, MemAddr = SrcB + r.
- CAP_B: capture MemReadData into the B row register. Clear the watchdog.
- EXEC:
  - AluOperation = latched op; AluColumnA and AluColumnB hold the row registers.
  - The watchdog increments every cycle.
  - On AluDone with AluError = 0: capture AluResult and go to WR.
  - On AluDone with AluError = 1: set Error and go to FIN, with no write for that row.
  - If the watchdog reaches TIMEOUT without AluDone: set Error and go to FIN.
- WR: MemWrite = 1, MemAddr = Dest + r, MemWriteData = captured result.
  - If r == ROWS-1, go to FIN. Otherwise r++ and go to RD_A.
- FIN: Done = 1 for one cycle, then IDLE.
- Addresses are computed modulo 2^AW: a base near the top of memory wraps to 0.
- AluOperation is 3'b000 in every state except EXEC. The ALU therefore sees at least 4 idle cycles between rows and never carries over a stale Done.
- Arithmetic: the block never modifies data lanes. Sign and overflow handling belong to the ALU.

## Timing
- Row cost = 4 + L cycles, where L is the number of EXEC cycles up to and including the AluDone cycle (L ≥ 1).
- Full command: accept edge, then 4·(4+L) cycles, then 1 FIN cycle. CmdReady returns high the cycle after FIN.
- NOP command: accept, then FIN, then IDLE. Done is high the cycle after accept.
- CmdValid while busy is ignored. The requester must hold CmdValid until it is accepted.
- AluDone outside EXEC is ignored.
- AluDone on the same cycle the watchdog expires: AluDone wins.
- ClearAll high at an edge:
  - From that edge, all outputs are at reset values, state is IDLE and Error is 0.
  - No Done pulse is produced.
  - Memory writes already performed stand.
  - The ClearAll edge takes priority over any simultaneous command accept.

## Structure
- Shared package matrix_pkg holds:
  - opcode constants OP_NOP = 3'b000 and OP_ADD = 3'b010;
  - LANE_W = 32 and ROWS = 4;
  - lane pack/unpack helpers;
  - the state enum.
- The block is a single module, matrix_alu_sequencer. The watchdog is an inline counter; no sub-module is needed.

## Test plan
- ADD, A rows all -4, B rows all 10, model ALU with L = 2, SrcA = 0x00, SrcB = 0x10, Dest = 0x20:
  - memory words 0x20..0x23 each hold four lanes of 6;
  - Done pulses at cycle 25 after accept;
  - Error = 0.
- NOP command: Done pulses the cycle after accept; MemRead and MemWrite stay 0 throughout.
- ALU never asserts Done:
  - Error = 1 and Done pulse after TIMEOUT cycles in EXEC on row 0;
  - no MemWrite occurs;
  - CmdReady returns high.
- AluError asserted with AluDone on row 2: rows 0–1 are written, row 2 is not, Error = 1, one Done pulse.
- Dest = 0xFE: result rows are written to 0xFE, 0xFF, 0x00, 0x01.
- ClearAll pulsed during EXEC of row 1:
  - the next cycle shows IDLE outputs, CmdReady = 1 and no Done pulse;
  - a new command issued immediately afterwards completes correctly.
